// File: rtl/amo_buffer_pkg.sv
// amo_buffer_pkg
// Shared types and default sizes for the multi-entry AMO buffer.
package amo_buffer_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StReq  = 1'b1
    } amo_buf_state_e;

    localparam int unsigned DefaultDepth     = 4;
    localparam int unsigned DefaultAddrWidth = 64;
    localparam int unsigned DefaultDataWidth = 64;

endpackage

// File: rtl/ariane_pkg.sv
// ariane_pkg (subset)
// Minimal copy of the core package, carrying only the AMO operation encoding.
// The AMO buffer uses it for its op ports.
package ariane_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'b0000,
        AMO_LR   = 4'b0001,
        AMO_SC   = 4'b0010,
        AMO_SWAP = 4'b0011,
        AMO_ADD  = 4'b0100,
        AMO_AND  = 4'b0101,
        AMO_OR   = 4'b0110,
        AMO_XOR  = 4'b0111,
        AMO_MAX  = 4'b1000,
        AMO_MAXU = 4'b1001,
        AMO_MIN  = 4'b1010,
        AMO_MINU = 4'b1011,
        AMO_CAS1 = 4'b1100,
        AMO_CAS2 = 4'b1101
    } amo_t;

endpackage

// File: rtl/amo_buffer_issue_fsm.sv
// amo_buffer_issue_fsm
// Issue sequencer for the AMO buffer: waits for a committed entry and an empty
// store buffer, raises the request, and strobes a pop when the cache acks.
// Optional macro AMO_BUF_BACK2BACK_EN: stay in REQ after an ack when another
// committed entry is ready, so consecutive requests have no idle bubble.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   has_committed_i     at least one committed entry is buffered
//   more_committed_i    at least two committed entries are buffered
//   no_st_pending_i     store buffer is empty
//   amo_ack_i           cache completed the outstanding request
//   req_valid_o         registered request valid (state == REQ)
//   pop_o               head entry retires this cycle
module amo_buffer_issue_fsm
    import amo_buffer_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic has_committed_i,
    input  logic more_committed_i,
    input  logic no_st_pending_i,
    input  logic amo_ack_i,
    output logic req_valid_o,
    output logic pop_o
);

    amo_buf_state_e state_q;
    logic           req_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            req_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (has_committed_i && no_st_pending_i) begin
                        state_q     <= StReq;
                        req_valid_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (amo_ack_i) begin
`ifdef AMO_BUF_BACK2BACK_EN
                        if (more_committed_i && no_st_pending_i) begin
                            state_q     <= StReq;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q     <= StIdle;
                            req_valid_q <= 1'b0;
                        end
`else
                        state_q     <= StIdle;
                        req_valid_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef AMO_BUF_BACK2BACK_EN
    logic unused_more_committed;
    assign unused_more_committed = more_committed_i;
`endif

    assign req_valid_o = req_valid_q;
    // Acks outside REQ are ignored.
    assign pop_o       = req_valid_q && amo_ack_i;

endmodule

// File: rtl/amo_buffer_multi.sv
// amo_buffer_multi
// In-order queue of up to DEPTH atomic memory operations with a commit
// boundary. Speculative (uncommitted) entries are dropped on flush; committed
// entries are issued one at a time to the cache once the store buffer drains,
// and each result comes back as a registered one-cycle pulse.
// Optional macro AMO_BUF_BACK2BACK_EN: back-to-back issue (see issue FSM).
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   flush_i                       drop uncommitted entries
//   valid_i/ready_o               push handshake (ready_o = not full)
//   amo_op_i, paddr_i, data_i,
//   data_size_i                   pushed AMO fields
//   commit_i                      oldest uncommitted entry commits
//   no_st_pending_i               store buffer empty
//   amo_req_*_o                   request to the cache (fields zero when idle)
//   amo_ack_i, amo_result_i       cache completion and result
//   result_valid_o, result_o      registered result pulse
//   usage_o, committed_o          occupied / committed entry counts
module amo_buffer_multi
    import amo_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = DefaultDepth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  ariane_pkg::amo_t             amo_op_i,
    input  logic [ADDR_WIDTH-1:0]        paddr_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic [1:0]                   data_size_i,
    input  logic                         commit_i,
    input  logic                         no_st_pending_i,
    output logic                         amo_req_valid_o,
    output ariane_pkg::amo_t             amo_req_op_o,
    output logic [ADDR_WIDTH-1:0]        amo_req_addr_o,
    output logic [DATA_WIDTH-1:0]        amo_req_data_o,
    output logic [1:0]                   amo_req_size_o,
    input  logic                         amo_ack_i,
    input  logic [DATA_WIDTH-1:0]        amo_result_i,
    output logic                         result_valid_o,
    output logic [DATA_WIDTH-1:0]        result_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic [$clog2(DEPTH+1)-1:0]   committed_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        ariane_pkg::amo_t        op;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   data;
        logic [1:0]              size;
    } entry_t;

    // Modular pointer add; ptr < DEPTH and n <= DEPTH, so one subtract suffices.
    function automatic logic [PtrW-1:0] wrap_add(logic [PtrW-1:0] ptr, logic [CntW-1:0] n);
        int unsigned s;
        s = 32'(ptr) + 32'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PtrW'(s);
    endfunction

    entry_t            mem_q [DEPTH];
    entry_t            head_entry;
    logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]   usage_q, usage_d, committed_q, committed_d;
    logic              push, commit_ok, pop, req_valid;
    logic              result_valid_q;
    logic [DATA_WIDTH-1:0] result_q;

    // ready depends on registered state only: no fall-through on a same-cycle pop.
    assign ready_o   = (usage_q < CntW'(DEPTH));
    // A push coinciding with a flush is speculative and is dropped.
    assign push      = valid_i && ready_o && !flush_i;
    // Only entries present at the start of the cycle can commit.
    assign commit_ok = commit_i && (committed_q < usage_q);

    always_comb begin
        head_d      = pop ? wrap_add(head_q, CntW'(1)) : head_q;
        committed_d = committed_q + CntW'(commit_ok) - CntW'(pop);
        if (flush_i) begin
            // The in-flight head is committed, so it always survives the flush.
            usage_d = committed_d;
            tail_d  = wrap_add(head_d, committed_d);
        end else begin
            usage_d = usage_q + CntW'(push) - CntW'(pop);
            tail_d  = push ? wrap_add(tail_q, CntW'(1)) : tail_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q         <= '0;
            tail_q         <= '0;
            usage_q        <= '0;
            committed_q    <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            usage_q        <= usage_d;
            committed_q    <= committed_d;
            result_valid_q <= pop;
            if (pop) result_q <= amo_result_i;
        end
    end

    // Storage needs no reset: request fields are gated by req_valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_q] <= '{op: amo_op_i, addr: paddr_i, data: data_i, size: data_size_i};
        end
    end

    amo_buffer_issue_fsm u_issue_fsm (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .has_committed_i  (committed_q != '0),
        .more_committed_i (committed_q > CntW'(1)),
        .no_st_pending_i  (no_st_pending_i),
        .amo_ack_i        (amo_ack_i),
        .req_valid_o      (req_valid),
        .pop_o            (pop)
    );

    assign head_entry      = mem_q[head_q];
    assign amo_req_valid_o = req_valid;
    assign amo_req_op_o    = req_valid ? head_entry.op : ariane_pkg::AMO_NONE;
    assign amo_req_addr_o  = req_valid ? head_entry.addr : '0;
    assign amo_req_data_o  = req_valid ? head_entry.data : '0;
    assign amo_req_size_o  = req_valid ? head_entry.size : '0;
    assign result_valid_o  = result_valid_q;
    assign result_o        = result_q;
    assign usage_o         = usage_q;
    assign committed_o     = committed_q;

endmodule

// File: tb/tb_amo_buffer_multi.sv
// Directed bench for amo_buffer_multi: DEPTH=4 instance (a) for most scenarios,
// DEPTH=3 instance (b) sharing the same inputs for the wrap-around scenario.
module tb_amo_buffer_multi;
    import ariane_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        flush, valid, commit, no_st, ack;
    amo_t        op;
    logic [63:0] paddr, wdata, res;
    logic [1:0]  size;

    logic        ready_a, rv_a, resv_a;
    amo_t        rop_a;
    logic [63:0] raddr_a, rdata_a, result_a;
    logic [1:0]  rsize_a;
    logic [2:0]  usage_a, comm_a;

    logic        ready_b, rv_b, resv_b;
    amo_t        rop_b;
    logic [63:0] raddr_b, rdata_b, result_b;
    logic [1:0]  rsize_b;
    logic [1:0]  usage_b, comm_b;

    int checks = 0;
    int errors = 0;

    amo_buffer_multi #(.DEPTH(4), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready_a),
        .amo_op_i(op), .paddr_i(paddr), .data_i(wdata), .data_size_i(size),
        .commit_i(commit), .no_st_pending_i(no_st),
        .amo_req_valid_o(rv_a), .amo_req_op_o(rop_a), .amo_req_addr_o(raddr_a),
        .amo_req_data_o(rdata_a), .amo_req_size_o(rsize_a),
        .amo_ack_i(ack), .amo_result_i(res),
        .result_valid_o(resv_a), .result_o(result_a), .usage_o(usage_a), .committed_o(comm_a)
    );

    amo_buffer_multi #(.DEPTH(3), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready_b),
        .amo_op_i(op), .paddr_i(paddr), .data_i(wdata), .data_size_i(size),
        .commit_i(commit), .no_st_pending_i(no_st),
        .amo_req_valid_o(rv_b), .amo_req_op_o(rop_b), .amo_req_addr_o(raddr_b),
        .amo_req_data_o(rdata_b), .amo_req_size_o(rsize_b),
        .amo_ack_i(ack), .amo_result_i(res),
        .result_valid_o(resv_b), .result_o(result_b), .usage_o(usage_b), .committed_o(comm_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0; valid = 1'b0; commit = 1'b0; no_st = 1'b0; ack = 1'b0;
        op = AMO_ADD; paddr = '0; wdata = '0; res = '0; size = 2'd3;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic seen;

        // Reset state
        do_reset();
        check("rst_ready", 64'(ready_a), 64'd1);
        check("rst_req_valid", 64'(rv_a), 64'd0);
        check("rst_req_data", rdata_a, 64'd0);
        check("rst_usage", 64'(usage_a), 64'd0);
        check("rst_committed", 64'(comm_a), 64'd0);
        check("rst_result_valid", 64'(resv_a), 64'd0);

        // Single AMO path
        no_st = 1'b1; valid = 1'b1; op = AMO_ADD; paddr = 64'h8000_1000; wdata = 64'd5;
        size = 2'd3;
        tick();
        valid = 1'b0;
        check("single_usage1", 64'(usage_a), 64'd1);
        check("single_uncommitted_noreq", 64'(rv_a), 64'd0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("single_committed", 64'(comm_a), 64'd1);
        check("single_req_not_yet", 64'(rv_a), 64'd0);
        tick();
        check("single_req_valid", 64'(rv_a), 64'd1);
        check("single_req_op", 64'(rop_a), 64'(AMO_ADD));
        check("single_req_addr", raddr_a, 64'h8000_1000);
        check("single_req_data", rdata_a, 64'd5);
        check("single_req_size", 64'(rsize_a), 64'd3);
        tick();
        check("single_req_held", 64'(rv_a), 64'd1);
        ack = 1'b1; res = 64'h11;
        tick();
        ack = 1'b0;
        check("single_req_dropped", 64'(rv_a), 64'd0);
        check("single_result_valid", 64'(resv_a), 64'd1);
        check("single_result", result_a, 64'h11);
        check("single_usage0", 64'(usage_a), 64'd0);
        check("single_committed0", 64'(comm_a), 64'd0);
        tick();
        check("single_result_pulse_end", 64'(resv_a), 64'd0);
        check("single_no_second_req", 64'(rv_a), 64'd0);

        // Full buffer
        do_reset();
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 64'(i);
            tick();
            check($sformatf("full_usage_%0d", i), 64'(usage_a), (i < 4) ? 64'(i + 1) : 64'd4);
            check($sformatf("full_ready_%0d", i), 64'(ready_a), (i < 3) ? 64'd1 : 64'd0);
        end
        valid = 1'b0;

        // Flush boundary (a same-cycle push is dropped)
        do_reset();
        valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wdata = 64'(i);
            paddr = 64'h1000 + 64'(i * 8);
            tick();
        end
        valid = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("flush_pre_committed", 64'(comm_a), 64'd1);
        check("flush_pre_usage", 64'(usage_a), 64'd3);
        flush = 1'b1; valid = 1'b1; wdata = 64'd9;
        tick();
        flush = 1'b0; valid = 1'b0;
        check("flush_usage", 64'(usage_a), 64'd1);
        check("flush_committed", 64'(comm_a), 64'd1);
        no_st = 1'b1;
        tick();
        check("flush_req_valid", 64'(rv_a), 64'd1);
        check("flush_req_data", rdata_a, 64'd1);
        ack = 1'b1; res = 64'h21;
        tick();
        ack = 1'b0;
        check("flush_result", result_a, 64'h21);
        check("flush_usage_after", 64'(usage_a), 64'd0);
        tick();
        tick();
        check("flush_no_more_req", 64'(rv_a), 64'd0);

        // Store drain gating
        do_reset();
        valid = 1'b1; wdata = 64'h33; paddr = 64'h2000;
        tick();
        valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (rv_a) seen = 1'b1;
        end
        check("drain_no_req_while_pending", 64'(seen), 64'd0);
        no_st = 1'b1;
        tick();
        check("drain_req_after_rise", 64'(rv_a), 64'd1);
        check("drain_req_data", rdata_a, 64'h33);
        no_st = 1'b0;
        repeat (3) tick();
        check("drain_req_held", 64'(rv_a), 64'd1);
        check("drain_req_data_held", rdata_a, 64'h33);
        ack = 1'b1; res = 64'h44;
        tick();
        ack = 1'b0;
        check("drain_result_valid", 64'(resv_a), 64'd1);
        check("drain_result", result_a, 64'h44);
        check("drain_req_done", 64'(rv_a), 64'd0);

        // Wrap-around on the DEPTH=3 instance
        do_reset();
        no_st = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            valid = 1'b1; wdata = 64'(k); paddr = 64'(k) << 4;
            tick();
            valid = 1'b0; commit = 1'b1;
            tick();
            commit = 1'b0;
            tick();
            check($sformatf("wrap_req_valid_%0d", k), 64'(rv_b), 64'd1);
            check($sformatf("wrap_req_data_%0d", k), rdata_b, 64'(k));
            ack = 1'b1; res = 64'(100 + k);
            tick();
            ack = 1'b0;
            check($sformatf("wrap_result_valid_%0d", k), 64'(resv_b), 64'd1);
            check($sformatf("wrap_result_%0d", k), result_b, 64'(100 + k));
        end
        check("wrap_usage_end", 64'(usage_b), 64'd0);

        // Back-to-back issue
        do_reset();
        valid = 1'b1; wdata = 64'hA;
        tick();
        wdata = 64'hB;
        tick();
        valid = 1'b0; commit = 1'b1;
        tick();
        tick();
        commit = 1'b0;
        check("b2b_committed", 64'(comm_a), 64'd2);
        no_st = 1'b1;
        tick();
        check("b2b_req1_valid", 64'(rv_a), 64'd1);
        check("b2b_req1_data", rdata_a, 64'hA);
        ack = 1'b1; res = 64'd1;
        tick();
        check("b2b_result1_valid", 64'(resv_a), 64'd1);
        check("b2b_result1", result_a, 64'd1);
`ifdef AMO_BUF_BACK2BACK_EN
        check("b2b_req2_adjacent", 64'(rv_a), 64'd1);
        check("b2b_req2_data", rdata_a, 64'hB);
        res = 64'd2;
        tick();
        ack = 1'b0;
`else
        check("b2b_bubble", 64'(rv_a), 64'd0);
        res = 64'd2;
        tick();
        check("b2b_req2_after_gap", 64'(rv_a), 64'd1);
        check("b2b_req2_data", rdata_a, 64'hB);
        check("b2b_idle_ack_ignored", 64'(comm_a), 64'd1);
        tick();
        ack = 1'b0;
`endif
        check("b2b_done", 64'(rv_a), 64'd0);
        check("b2b_result2_valid", 64'(resv_a), 64'd1);
        check("b2b_result2", result_a, 64'd2);
        check("b2b_usage_end", 64'(usage_a), 64'd0);

        // Reset while a request is outstanding
        no_st = 1'b1; valid = 1'b1; wdata = 64'h55;
        tick();
        valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        check("midreq_req_valid", 64'(rv_a), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreq_req_dropped", 64'(rv_a), 64'd0);
        check("midreq_usage", 64'(usage_a), 64'd0);
        check("midreq_committed", 64'(comm_a), 64'd0);
        check("midreq_ready", 64'(ready_a), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
